// File: rtl/glb_stream_reader_pkg.sv
// Shared definitions for the global-buffer stream reader.
// Holds the FSM state encodings and the read-latency legality check used at
// elaboration time by glb_stream_reader.
package glb_stream_reader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // The BRAM port only supports LOW_LATENCY (1) and HIGH_PERFORMANCE (2).
  function automatic bit latency_ok(input int rl);
    return (rl == 1) || (rl == 2);
  endfunction

endpackage

// File: rtl/glb_skid_fifo.sv
// Synchronous FIFO with a head-visible read port and an occupancy count.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push, push_data  write strobe and word
//   pop              remove head word (ignored when empty)
//   head_data        current head word (meaningful only when count != 0)
//   count            number of stored words
module glb_skid_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import glb_stream_reader_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The reader's credit scheme must never let a word arrive at a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/glb_stream_reader.sv
// Read-side controller for the true_dpbram global buffer.
// Issues a strided burst of reads on one BRAM port, tracks the fixed read
// latency with an inflight shift register, and buffers returned words in a
// credit-protected skid FIFO presented as a valid/ready stream with last.
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   cmd_valid/cmd_ready                   burst command handshake
//   cmd_base, cmd_len, cmd_stride         first address, word count, increment
//   m_valid/m_ready, m_data, m_last       output stream
//   done                                  one-cycle pulse, burst delivered
//   bram_addr, bram_en, bram_we,
//   bram_regce, bram_rst, bram_dout       BRAM port (read-only use)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a command; cmd_ready high
// RUN      | issuing reads while credit is available
// DRAIN    | all reads issued; waiting for the last word to be popped
module glb_stream_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = READ_LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic                  bram_regce,
  output logic                  bram_rst,
  input  logic [DATA_WIDTH-1:0] bram_dout
);
  import glb_stream_reader_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("glb_stream_reader: READ_LATENCY must be 1 or 2");
  end
  if (FIFO_DEPTH < READ_LATENCY + 2) begin : g_bad_depth
    $error("glb_stream_reader: FIFO_DEPTH must be at least READ_LATENCY+2");
  end

  logic [1:0]              state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [ADDR_WIDTH-1:0]   stride_q;
  logic [ADDR_WIDTH:0]     remaining;
  logic [READ_LATENCY-1:0] infl_valid;
  logic [READ_LATENCY-1:0] infl_last;
  logic [READ_LATENCY:0]   infl_valid_ext;
  logic [READ_LATENCY:0]   infl_last_ext;
  logic [CNT_W-1:0]        infl_cnt;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W:0]          used;
  logic                    credit_ok;
  logic                    issue;
  logic                    last_issue;
  logic                    pop;
  logic [DATA_WIDTH:0]     head;

  assign cmd_ready  = (state == ST_IDLE);
  assign bram_we    = 1'b0;
  assign bram_regce = 1'b1;
  assign bram_rst   = rst;
  assign bram_addr  = addr;
  assign bram_en    = issue;

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      infl_cnt = infl_cnt + CNT_W'(infl_valid[i]);
    end
  end

  // Credit uses only registered occupancy; a same-cycle pop is not counted.
  assign used       = {1'b0, fifo_count} + {1'b0, infl_cnt};
  assign credit_ok  = used < (CNT_W + 1)'(FIFO_DEPTH);
  assign issue      = (state == ST_RUN) && credit_ok;
  assign last_issue = (remaining == (ADDR_WIDTH + 1)'(1));

  assign infl_valid_ext = {infl_valid, issue};
  assign infl_last_ext  = {infl_last, issue && last_issue};

  always_ff @(posedge clk) begin
    if (rst) begin
      infl_valid <= '0;
      infl_last  <= '0;
    end else begin
      infl_valid <= infl_valid_ext[READ_LATENCY-1:0];
      infl_last  <= infl_last_ext[READ_LATENCY-1:0];
    end
  end

  glb_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (infl_valid[READ_LATENCY-1]),
    .push_data ({infl_last[READ_LATENCY-1], bram_dout}),
    .pop       (pop),
    .head_data (head),
    .count     (fifo_count)
  );

  // Head is gated so the outputs read zero whenever the stream is empty.
  assign m_valid = (fifo_count != '0);
  assign m_data  = m_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_last  = m_valid && head[DATA_WIDTH];
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      stride_q  <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              addr      <= cmd_base;
              stride_q  <= cmd_stride;
              remaining <= cmd_len;
              state     <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            addr      <= addr + stride_q;
            remaining <= remaining - (ADDR_WIDTH + 1)'(1);
            if (last_issue) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Popping the tagged last word implies nothing is inflight or queued.
          if (pop && m_last) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glb_stream_reader.sv
module tb_glb_stream_reader;

  logic       clk = 1'b0;
  logic       rst;

  logic       cmd_valid, cmd_ready;
  logic [9:0] cmd_base, cmd_stride;
  logic [10:0] cmd_len;
  logic       m_valid, m_ready, m_last, done;
  logic [7:0] m_data;
  logic [9:0] bram_addr;
  logic       bram_en, bram_we, bram_regce, bram_rst;
  logic [7:0] bram_dout, bram_p1;

  logic       ll_cmd_valid, ll_cmd_ready;
  logic [9:0] ll_cmd_base, ll_cmd_stride;
  logic [10:0] ll_cmd_len;
  logic       ll_m_valid, ll_m_ready, ll_m_last, ll_done;
  logic [7:0] ll_m_data;
  logic [9:0] ll_bram_addr;
  logic       ll_bram_en, ll_bram_we, ll_bram_regce, ll_bram_rst;
  logic [7:0] ll_bram_dout;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [9:0] addr_q[$];

  typedef struct {
    logic [9:0]  base;
    logic [10:0] len;
    logic [9:0]  stride;
    logic [3:0]  rdy_pat;
    int          exp_first;
    int          exp_span;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  glb_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .READ_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_stride(cmd_stride),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .done(done),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_regce(bram_regce), .bram_rst(bram_rst), .bram_dout(bram_dout)
  );

  glb_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .READ_LATENCY(1)) dut_ll (
    .clk(clk), .rst(rst),
    .cmd_valid(ll_cmd_valid), .cmd_ready(ll_cmd_ready),
    .cmd_base(ll_cmd_base), .cmd_len(ll_cmd_len), .cmd_stride(ll_cmd_stride),
    .m_valid(ll_m_valid), .m_ready(ll_m_ready), .m_data(ll_m_data), .m_last(ll_m_last),
    .done(ll_done),
    .bram_addr(ll_bram_addr), .bram_en(ll_bram_en), .bram_we(ll_bram_we),
    .bram_regce(ll_bram_regce), .bram_rst(ll_bram_rst), .bram_dout(ll_bram_dout)
  );

  function automatic logic [7:0] mem_word(input logic [9:0] a);
    return a[7:0];
  endfunction

  // BRAM models: two-stage (HIGH_PERFORMANCE) and one-stage (LOW_LATENCY).
  always @(posedge clk) begin
    if (bram_en) bram_p1 <= mem_word(bram_addr);
    if (bram_regce) bram_dout <= bram_p1;
    if (ll_bram_en) ll_bram_dout <= mem_word(ll_bram_addr);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic push_expected(input logic [9:0] base, input logic [10:0] len,
                               input logic [9:0] stride);
    for (int i = 0; i < int'(len); i++) begin
      logic [9:0] a;
      a = base + 10'(i) * stride;
      addr_q.push_back(a);
      exp_q.push_back({(i == int'(len) - 1), mem_word(a)});
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_vec(input vec_t v);
    int  first_k;
    int  last_pop_k;
    bit  got_done;
    first_k    = -1;
    last_pop_k = 0;
    got_done   = 1'b0;
    push_expected(v.base, v.len, v.stride);
    cmd_base   = v.base;
    cmd_len    = v.len;
    cmd_stride = v.stride;
    cmd_valid  = 1'b1;
    m_ready    = v.rdy_pat[0];
    @(negedge clk);
    check("cmd_ready_idle", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      m_ready = v.rdy_pat[k % 4];
      @(negedge clk);
      if (bram_en) begin
        if (addr_q.size() == 0) check("spurious_bram_en", 1, 0);
        else check("bram_addr", int'(bram_addr), int'(addr_q.pop_front()));
      end
      check("fifo_bound", int'(dut.u_fifo.count <= 4), 1);
      if (m_valid) begin
        if (first_k < 0) first_k = k;
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          check("m_data", int'(m_data), int'(exp_q[0][7:0]));
          check("m_last", int'(m_last), int'(exp_q[0][8]));
          if (m_ready) begin
            void'(exp_q.pop_front());
            last_pop_k = k;
          end
        end
      end
      if (done) begin
        check("done_cycle", k, last_pop_k + 1);
        check("cmd_ready_at_done", int'(cmd_ready), 1);
        got_done = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got_done) check("done_timeout", 0, 1);
    check("first_valid_cycle", first_k, v.exp_first);
    if (v.exp_span >= 0) check("throughput_span", last_pop_k - first_k, v.exp_span);
    check("words_left", exp_q.size(), 0);
    check("addrs_left", addr_q.size(), 0);
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  pops;
    bit  got_done;

    vecs[0] = '{10'h010, 11'd4, 10'd1,   4'b1111, 4, 3};
    vecs[1] = '{10'h3FE, 11'd3, 10'd3,   4'b1111, 4, 2};
    vecs[2] = '{10'h080, 11'd8, 10'd1,   4'b1001, 4, -1};
    vecs[3] = '{10'h000, 11'd0, 10'd1,   4'b1111, -1, -1};
    vecs[4] = '{10'h123, 11'd1, 10'd5,   4'b1111, 4, 0};
    vecs[5] = '{10'h200, 11'd6, 10'h3FF, 4'b0011, 4, -1};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; cmd_stride = '0; m_ready = 1'b0;
    ll_cmd_valid = 1'b0; ll_cmd_base = '0; ll_cmd_len = '0; ll_cmd_stride = '0;
    ll_m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_last", int'(m_last), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_done", int'(done), 0);
    check("rst_bram_en", int'(bram_en), 0);
    check("rst_bram_addr", int'(bram_addr), 0);
    check("rst_bram_we", int'(bram_we), 0);
    check("rst_bram_regce", int'(bram_regce), 1);
    check("rst_bram_rst", int'(bram_rst), 1);
    check("rst_ll_m_valid", int'(ll_m_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("bram_rst_released", int'(bram_rst), 0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a long burst.
    push_expected(10'h020, 11'd16, 10'd1);
    cmd_base = 10'h020; cmd_len = 11'd16; cmd_stride = 10'd1;
    cmd_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    pops = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (m_valid && exp_q.size() != 0) begin
        check("rb_m_data", int'(m_data), int'(exp_q[0][7:0]));
        void'(exp_q.pop_front());
        pops++;
      end
      @(posedge clk); #1;
      if (pops == 5) break;
    end
    check("rb_pops_before_reset", pops, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rb_m_valid", int'(m_valid), 0);
    check("rb_bram_en", int'(bram_en), 0);
    check("rb_cmd_ready", int'(cmd_ready), 1);
    check("rb_done", int'(done), 0);
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    run_vec('{10'h100, 11'd2, 10'd1, 4'b1111, 4, 1});

    // LOW_LATENCY instance: first word in cycle 3, one word per cycle.
    ll_cmd_base = 10'h040; ll_cmd_len = 11'd4; ll_cmd_stride = 10'd1;
    ll_cmd_valid = 1'b1; ll_m_ready = 1'b1;
    @(posedge clk); #1;
    ll_cmd_valid = 1'b0;
    pops = 0;
    got_done = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ll_m_valid) begin
        check("ll_cycle", k, 3 + pops);
        check("ll_data", int'(ll_m_data), 8'h40 + pops);
        check("ll_last", int'(ll_m_last), int'(pops == 3));
        pops++;
      end
      if (ll_done) begin
        check("ll_done_cycle", k, 7);
        got_done = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    check("ll_words", pops, 4);
    check("ll_done_seen", int'(got_done), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
